shared_mem_arbiter: RTL and testbench
=====================================

# shared_mem_arbiter

Round-robin arbiter that lets the two cores of the multicore CPU share one single-port, synchronous-read data memory. It sits in the `sys_clk` domain, between the cores' load/store ports and the shared RAM. It serialises their accesses and returns read data and a one-cycle acknowledge to the winning core. Only one memory access is in flight at a time.

## Interface

Parameters:
- `DATA_SIZE`, 32: data word width.
- `MEM_SIZE`, 8: memory address width (2^MEM_SIZE words).

Ports:
- `sys_clk`  in  1  clock; the block has a single clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-core access request; bit i belongs to core i.
- `we`  in  2  per-core write enable; qualified by `req`.
- `addr0`, `addr1`  in  MEM_SIZE  per-core word address.
- `wdata0`, `wdata1`  in  DATA_SIZE  per-core write data.
- `ack`  out  2  one-cycle completion pulse per core.
- `rdata0`, `rdata1`  out  DATA_SIZE  per-core read data; valid while `ack[i]` is high, held afterwards.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  MEM_SIZE  memory address.
- `mem_wdata`  out  DATA_SIZE  memory write data.
- `mem_rdata`  in  DATA_SIZE  memory read data; valid one cycle after `mem_en` is sampled.

## Operation

- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - Form the effective request as `req` with `ack` masked off. A core whose `ack` is high this cycle is not eligible.
  - If any effective request is present: pick a winner, latch the owner, and go to ISSUE.
  - On the same edge, register `mem_en`=1, `mem_we`=`we[owner]`, `mem_addr`, and `mem_wdata` from the owner's inputs.
  - Otherwise stay in IDLE with `mem_en`=0.
- **ISSUE**
  - Memory samples the strobes at the closing edge.
  - Clear `mem_en` and `mem_we`; go to WAIT.
- **WAIT**
  - For a read, register `rdata[owner]` <= `mem_rdata`. For a write, `rdata[owner]` is unchanged.
  - Register `ack[owner]`=1 and go to IDLE.
  - `ack` clears on the following edge unless a new completion occurs.
- **Winner selection**
  - Single eligible requester: it wins.
  - Both eligible: the core other than the last-granted one wins.
  - The last-granted pointer updates on every grant.
- Requester rules:
  - Hold `req`, `we`, addr, and wdata stable from assertion until `ack` is seen.
  - `req` may drop or re-assert in the cycle after `ack`.
  - Dropping `req` before `ack` is a protocol violation; the latched access completes anyway.
- `mem_addr` and `mem_wdata` hold their last value when idle.

## Timing

- Reset values: state IDLE, `ack`=0, `rdata0`=`rdata1`=0, `mem_en`=`mem_we`=0, `mem_addr`=0, `mem_wdata`=0, last-granted=core 1 (so core 0 wins the first tie).
- Latency: `req` sampled at edge 0, `mem_en` high in cycle 1, `mem_rdata` valid in cycle 2, `ack`/`rdata` in cycle 3. That is 3 cycles from request to acknowledge.
- Throughput: one access per 3 cycles. A pending request from the other core is granted in the `ack` cycle (IDLE), giving back-to-back accesses with no bubble.
- The same core re-requesting immediately is granted one cycle after its `ack`.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). `mem_en` drops at once, so an access whose ISSUE edge has not yet occurred is not performed. No `ack` is generated for the aborted access.

## Structure

- Shared package `multicore_pkg`: `NUM_CORES`=2 and the `arb_state_t` enum (IDLE, ISSUE, WAIT). `DATA_SIZE` and `MEM_SIZE` remain module parameters.
- One natural sub-module, `rr_pick2`: a combinational 2-way round-robin picker. Inputs: effective request and last-granted pointer. Outputs: grant valid and winner index.
- Everything else (FSM, latched owner, memory-side registers, per-core rdata/ack registers) lives in `shared_mem_arbiter`.

## Test plan

- **Single read:** memory[0x10]=0xDEADBEEF; core 0 `req`=1, `we`=0, `addr0`=0x10 → `mem_en` high for exactly 1 cycle with `mem_addr`=0x10. `ack`=2'b01 three cycles after `req` is sampled, with `rdata0`=0xDEADBEEF. `rdata1` stays 0.
- **Write then read:** core 1 writes 0x12345678 to 0x05 → `mem_we`=1 for 1 cycle and `ack[1]` pulses with `rdata1` unchanged. Core 1 then reads 0x05 → `rdata1`=0x12345678.
- **Simultaneous requests after reset:** both cores read 0x01 and 0x02 → core 0 acked first. Core 1's `mem_en` is issued in core 0's `ack` cycle, and `ack[1]` arrives 3 cycles after `ack[0]`.
- **Sustained contention:** both cores keep `req` high for 6 accesses each → grants alternate 0,1,0,1,… The same core is never acked twice in a row while the other is waiting.
- **Ack masking:** core 0 only, `req` held high through its `ack` cycle and then dropped → exactly one memory access and one `ack` pulse.
- **Reset mid-access:** assert `resetn`=0 during ISSUE → `mem_en`, `ack`, and `rdata` read 0 immediately. After release the FSM is in IDLE and the next request completes normally in 3 cycles.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared definitions for the multicore CPU memory subsystem: core count and arbiter FSM states.
package multicore_pkg;

  localparam int NUM_CORES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/shared_mem_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker; zero latency.
// Requesters are never stalled here; a loser simply waits for the next grant opportunity.
module rr_pick2
  import multicore_pkg::*;
(
  input  logic [NUM_CORES-1:0] req_eff,
  input  logic                 last_gnt,
  output logic                 gnt_vld,
  output logic                 gnt_idx
);

  always_comb begin
    gnt_vld = |req_eff;
    gnt_idx = 1'b0;
    if (&req_eff) begin
      gnt_idx = ~last_gnt;
    end else begin
      gnt_idx = req_eff[1];
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Two-core round-robin arbiter for one synchronous-read RAM; req-to-ack latency 3 cycles.
// Losing core holds req until its ack; one access in flight, pending core granted in the ack cycle.
module shared_mem_arbiter
  import multicore_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int MEM_SIZE  = 8
) (
  input  logic                 sys_clk,
  input  logic                 resetn,
  input  logic [1:0]           req,
  input  logic [1:0]           we,
  input  logic [MEM_SIZE-1:0]  addr0,
  input  logic [MEM_SIZE-1:0]  addr1,
  input  logic [DATA_SIZE-1:0] wdata0,
  input  logic [DATA_SIZE-1:0] wdata1,
  output logic [1:0]           ack,
  output logic [DATA_SIZE-1:0] rdata0,
  output logic [DATA_SIZE-1:0] rdata1,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [MEM_SIZE-1:0]  mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  arb_state_t state_q, state_d;
  logic       owner_q;
  logic       last_gnt_q;
  logic       op_we_q;
  logic [1:0] req_eff;
  logic       gnt_vld;
  logic       gnt_idx;

  // A core being acked this cycle still shows req high; it must not be re-granted yet.
  assign req_eff = req & ~ack;

  rr_pick2 u_pick (
    .req_eff  (req_eff),
    .last_gnt (last_gnt_q),
    .gnt_vld  (gnt_vld),
    .gnt_idx  (gnt_idx)
  );

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      owner_q    <= 1'b0;
      last_gnt_q <= 1'b1;
      op_we_q    <= 1'b0;
      ack        <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      ack <= '0;
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            owner_q    <= gnt_idx;
            last_gnt_q <= gnt_idx;
            op_we_q    <= we[gnt_idx];
            mem_en     <= 1'b1;
            mem_we     <= we[gnt_idx];
            mem_addr   <= gnt_idx ? addr1 : addr0;
            mem_wdata  <= gnt_idx ? wdata1 : wdata0;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
        end
        WAIT: begin
          ack[owner_q] <= 1'b1;
          // op_we_q is used rather than we[] so a requester dropping early cannot corrupt rdata.
          if (!op_we_q) begin
            if (owner_q) rdata1 <= mem_rdata;
            else         rdata0 <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a behavioural synchronous-read RAM.
module tb_shared_mem_arbiter;

  logic        sys_clk = 1'b0;
  logic        resetn;
  logic [1:0]  req, we;
  logic [7:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [1:0]  ack;
  logic [31:0] rdata0, rdata1;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  shared_mem_arbiter #(.DATA_SIZE(32), .MEM_SIZE(8)) dut (
    .sys_clk   (sys_clk),
    .resetn    (resetn),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .ack       (ack),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always @(posedge sys_clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Ticks until any ack bit in mask rises; cyc = budget+1 if it never does.
  task automatic wait_ack(input logic [1:0] mask, input int budget, output int cyc);
    cyc = budget + 1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if ((ack & mask) != 2'b00) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    int cyc;
    int n_en, n_ack;
    bit drop_next;
    logic [7:0] held_addr;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h01] = 32'hA1A1A1A1;
    mem[8'h02] = 32'hB2B2B2B2;
    mem[8'h20] = 32'h20202020;
    mem[8'h21] = 32'h21212121;
    mem_rdata = 32'h0;
    req = 2'b00; we = 2'b00;
    addr0 = 8'h0; addr1 = 8'h0; wdata0 = 32'h0; wdata1 = 32'h0;
    resetn = 1'b0;
    #1;
    check("rst_ack", {30'b0, ack}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", {24'b0, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    tick(); tick();
    resetn = 1'b1;
    tick();

    // Single read by core 0
    req = 2'b01; we = 2'b00; addr0 = 8'h10;
    tick();
    check("rd_en_c1", {31'b0, mem_en}, 32'h1);
    check("rd_addr_c1", {24'b0, mem_addr}, 32'h10);
    check("rd_we_c1", {31'b0, mem_we}, 32'h0);
    tick();
    check("rd_en_c2", {31'b0, mem_en}, 32'h0);
    check("rd_ack_c2", {30'b0, ack}, 32'h0);
    tick();
    check("rd_ack_c3", {30'b0, ack}, 32'h1);
    check("rd_rdata0", rdata0, 32'hDEADBEEF);
    check("rd_rdata1", rdata1, 32'h0);
    req = 2'b00;
    tick();
    check("rd_ack_clr", {30'b0, ack}, 32'h0);
    check("rd_en_idle", {31'b0, mem_en}, 32'h0);
    check("rd_rdata0_hold", rdata0, 32'hDEADBEEF);
    check("rd_addr_hold", {24'b0, mem_addr}, 32'h10);

    // Core 1 write then read back
    req = 2'b10; we = 2'b10; addr1 = 8'h05; wdata1 = 32'h12345678;
    tick();
    check("wr_en", {31'b0, mem_en}, 32'h1);
    check("wr_we", {31'b0, mem_we}, 32'h1);
    check("wr_addr", {24'b0, mem_addr}, 32'h05);
    check("wr_wdata", mem_wdata, 32'h12345678);
    tick();
    check("wr_we_clr", {31'b0, mem_we}, 32'h0);
    tick();
    check("wr_ack", {30'b0, ack}, 32'h2);
    check("wr_rdata1_unch", rdata1, 32'h0);
    check("wr_mem", mem[8'h05], 32'h12345678);
    req = 2'b00; we = 2'b00;
    tick();
    req = 2'b10;
    wait_ack(2'b11, 10, cyc);
    check("wr_rd_lat", cyc, 3);
    check("wr_rd_ack", {30'b0, ack}, 32'h2);
    check("wr_rd_rdata1", rdata1, 32'h12345678);
    req = 2'b00;
    tick();

    // Simultaneous requests straight after reset
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    tick();
    req = 2'b11; we = 2'b00; addr0 = 8'h01; addr1 = 8'h02;
    tick();
    check("sim_en0", {31'b0, mem_en}, 32'h1);
    check("sim_addr0", {24'b0, mem_addr}, 32'h01);
    tick();
    tick();
    check("sim_ack0", {30'b0, ack}, 32'h1);
    check("sim_rdata0", rdata0, 32'hA1A1A1A1);
    req = 2'b10;
    tick();
    check("sim_en1", {31'b0, mem_en}, 32'h1);
    check("sim_addr1", {24'b0, mem_addr}, 32'h02);
    check("sim_ack_gap", {30'b0, ack}, 32'h0);
    tick();
    tick();
    check("sim_ack1", {30'b0, ack}, 32'h2);
    check("sim_rdata1", rdata1, 32'hB2B2B2B2);
    req = 2'b00;
    tick();

    // Sustained contention: 12 acks must alternate 0,1,0,1,...
    addr0 = 8'h20; addr1 = 8'h21;
    req = 2'b11;
    for (int k = 0; k < 12; k++) begin
      wait_ack(2'b11, 10, cyc);
      check($sformatf("cont_lat%0d", k), cyc, 3);
      check($sformatf("cont_who%0d", k), {30'b0, ack}, (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k == 11) req = 2'b00;
    end
    check("cont_rdata0", rdata0, 32'h20202020);
    check("cont_rdata1", rdata1, 32'h21212121);
    tick();
    check("cont_quiet", {31'b0, mem_en}, 32'h0);

    // Ack masking: req held through ack cycle, dropped the cycle after
    req = 2'b01; addr0 = 8'h10;
    n_en = 0; n_ack = 0; drop_next = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (drop_next) begin
        req = 2'b00;
        drop_next = 1'b0;
      end
      if (mem_en) n_en++;
      if (ack[0]) begin
        n_ack++;
        drop_next = 1'b1;
      end
    end
    check("mask_n_en", n_en, 1);
    check("mask_n_ack", n_ack, 1);
    check("mask_rdata0", rdata0, 32'hDEADBEEF);

    // Reset during ISSUE aborts the access
    req = 2'b01; we = 2'b00; addr0 = 8'h01;
    tick();
    check("mid_en_pre", {31'b0, mem_en}, 32'h1);
    held_addr = 8'h01;
    #2;
    resetn = 1'b0;
    #1;
    check("mid_en", {31'b0, mem_en}, 32'h0);
    check("mid_ack", {30'b0, ack}, 32'h0);
    check("mid_rdata0", rdata0, 32'h0);
    check("mid_rdata1", rdata1, 32'h0);
    check("mid_addr", {24'b0, mem_addr}, 32'h0);
    req = 2'b00;
    tick();
    check("mid_no_ack", {30'b0, ack}, 32'h0);
    resetn = 1'b1;
    tick();
    req = 2'b10; we = 2'b00; addr1 = 8'h05;
    wait_ack(2'b11, 10, cyc);
    check("post_lat", cyc, 3);
    check("post_ack", {30'b0, ack}, 32'h2);
    check("post_rdata1", rdata1, 32'h12345678);
    check("post_rdata0", rdata0, 32'h0);
    req = 2'b00;
    tick();
    check("post_ack_clr", {30'b0, ack}, 32'h0);
    check("post_hold", rdata1, 32'h12345678);
    check("post_addr_hold", {24'b0, mem_addr}, 32'h05);
    check("post_mem_untouched", mem[held_addr], 32'hA1A1A1A1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
